lif_step_scheduler: RTL and testbench

Time-multiplexed controller sharing one LIF update datapath among `N_NEURONS` neurons. Holds each neuron's membrane potential and input current in local register files. On each `step_start` it scans every neuron once, applying leak, integrate, fire and reset, and queues spike IDs into an output FIFO. It sits between the host or stimulus logic that writes currents and the downstream spike consumer.

---
 rtl/lif_pkg.sv | 21 ++
 rtl/lif_update.sv | 58 +++++
 rtl/lif_step_scheduler.sv | 162 ++++++++++++++++
 tb/tb_lif_step_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF step scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lif_pkg;

  // Default datapath width for potential, current, threshold and leak.
  localparam int LIF_WIDTH = 16;

  // Leak factor is a Q0.16 fraction; the product is shifted down by this.
  localparam int Q_SHIFT = 16;

  // Saturation ceiling for the default width.
  localparam logic [LIF_WIDTH-1:0] SAT_MAX = {LIF_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lif_update.sv
// Combinational LIF neuron update: leak, integrate, saturate, threshold compare.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether to commit v_next.
//
// Ports: v/cur = present potential and input current; leak_factor (Q0.16),
// threshold, reset_potential = step config; v_next/fire = update result.
// Optional macro LIF_REFRACTORY_EN adds refrac_active: when high the neuron
// keeps v unchanged and cannot fire.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH = LIF_WIDTH
) (
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] leak_factor,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] reset_potential,
`ifdef LIF_REFRACTORY_EN
  input  logic             refrac_active,
`endif
  output logic [WIDTH-1:0] v_next,
  output logic             fire
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   leak;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   sat;
  logic               fire_raw;

  always_comb begin
    prod = {{WIDTH{1'b0}}, v} * {{WIDTH{1'b0}}, leak_factor};
    leak = WIDTH'(prod >> Q_SHIFT);
    // leak <= v always, so the subtraction never wraps; the extra bit
    // only catches overflow from adding the current.
    sum  = {1'b0, v} - {1'b0, leak} + {1'b0, cur};
    sat  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    fire_raw = (sat >= threshold);
  end

`ifdef LIF_REFRACTORY_EN
  always_comb begin
    v_next = fire_raw ? reset_potential : sat;
    fire   = fire_raw;
    if (refrac_active) begin
      v_next = v;
      fire   = 1'b0;
    end
  end
`else
  always_comb begin
    v_next = fire_raw ? reset_potential : sat;
    fire   = fire_raw;
  end
`endif

endmodule

// File: rtl/lif_step_scheduler.sv
// Scans N_NEURONS through one shared LIF datapath per step, queuing spike IDs.
// Latency: accept + one neuron per cycle + one DONE cycle (N+1 cycles to step_done).
// Backpressure: scan stalls on a firing neuron while the spike FIFO is full and not popping.
//
// Ports: clk, reset (async active-low); step_start/step_busy/step_done control
// a step; leak_factor/threshold/reset_potential latched at accept;
// cur_wr_en/addr/data write persistent input currents; spike_valid/ready/id
// is the FIFO head. Optional macro LIF_REFRACTORY_EN adds per-neuron
// refractory counters loaded with REFRAC_STEPS on fire.
module lif_step_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 16,
  parameter int WIDTH      = LIF_WIDTH,
  parameter int FIFO_DEPTH = 4
`ifdef LIF_REFRACTORY_EN
  , parameter int REFRAC_STEPS = 2
`endif
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      step_start,
  input  logic [WIDTH-1:0]                          leak_factor,
  input  logic [WIDTH-1:0]                          threshold,
  input  logic [WIDTH-1:0]                          reset_potential,
  input  logic                                      cur_wr_en,
  input  logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] cur_wr_addr,
  input  logic [WIDTH-1:0]                          cur_wr_data,
  output logic                                      step_busy,
  output logic                                      step_done,
  output logic                                      spike_valid,
  input  logic                                      spike_ready,
  output logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] spike_id
);

  localparam int IDW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  state_t             state_q;
  logic [IDW-1:0]     idx_q;
  logic [WIDTH-1:0]   lf_q, thr_q, rp_q;
  logic [WIDTH-1:0]   v_q   [N_NEURONS];
  logic [WIDTH-1:0]   cur_q [N_NEURONS];
  logic [IDW-1:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        cnt_q;

  logic [WIDTH-1:0]   v_next;
  logic               fire;
  logic               in_run, fifo_full, pop, stall, advance, push, last;

`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 1);
  logic [RW-1:0] refrac_q [N_NEURONS];
  logic          refrac_active;
  assign refrac_active = (refrac_q[idx_q] != '0);
`endif

  lif_update #(.WIDTH(WIDTH)) u_update (
    .v               (v_q[idx_q]),
    .cur             (cur_q[idx_q]),
    .leak_factor     (lf_q),
    .threshold       (thr_q),
    .reset_potential (rp_q),
`ifdef LIF_REFRACTORY_EN
    .refrac_active   (refrac_active),
`endif
    .v_next          (v_next),
    .fire            (fire)
  );

  assign in_run      = (state_q == ST_RUN);
  assign spike_valid = (cnt_q != '0);
  assign fifo_full   = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop         = spike_valid & spike_ready;
  // A pop in the same cycle frees a slot, so it clears the stall.
  assign stall       = in_run & fire & fifo_full & ~pop;
  assign advance     = in_run & ~stall;
  assign push        = advance & fire;
  assign last        = (idx_q == IDW'(N_NEURONS - 1));

  assign step_busy = (state_q != ST_IDLE);
  assign step_done = (state_q == ST_DONE);
  assign spike_id  = fifo_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lf_q    <= '0;
      thr_q   <= '0;
      rp_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (step_start) begin
          lf_q    <= leak_factor;
          thr_q   <= threshold;
          rp_q    <= reset_potential;
          idx_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: if (advance) begin
          if (last) state_q <= ST_DONE;
          else      idx_q   <= idx_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Potential writeback; skipped while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_NEURONS; i++) v_q[i] <= '0;
    end else if (advance) begin
      v_q[idx_q] <= v_next;
    end
  end

  // The update combinationally reads the pre-edge current, so a write to the
  // neuron being updated takes effect on the next step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_NEURONS; i++) cur_q[i] <= '0;
    end else if (cur_wr_en) begin
      cur_q[cur_wr_addr] <= cur_wr_data;
    end
  end

`ifdef LIF_REFRACTORY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_NEURONS; i++) refrac_q[i] <= '0;
    end else if (advance) begin
      if (fire)               refrac_q[idx_q] <= RW'(REFRAC_STEPS);
      else if (refrac_active) refrac_q[idx_q] <= refrac_q[idx_q] - 1'b1;
    end
  end
`endif

  // Spike FIFO: circular buffer, pointer plus occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= idx_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Self-checking bench for lif_step_scheduler: directed scenarios plus random steps
// checked against an arithmetic per-step reference model and spike-order queue.
module tb_lif_step_scheduler;

  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          step_start;
  logic [W-1:0]  leak_factor, threshold, reset_potential;
  logic          cur_wr_en;
  logic [1:0]    cur_wr_addr;
  logic [W-1:0]  cur_wr_data;
  logic          step_busy, step_done, spike_valid, spike_ready;
  logic [1:0]    spike_id;

  always #5 clk = ~clk;

  lif_step_scheduler #(.N_NEURONS(N), .WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .step_start      (step_start),
    .leak_factor     (leak_factor),
    .threshold       (threshold),
    .reset_potential (reset_potential),
    .cur_wr_en       (cur_wr_en),
    .cur_wr_addr     (cur_wr_addr),
    .cur_wr_data     (cur_wr_data),
    .step_busy       (step_busy),
    .step_done       (step_done),
    .spike_valid     (spike_valid),
    .spike_ready     (spike_ready),
    .spike_id        (spike_id)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: potentials, currents, refractory counters.
  longint mv[N];
  longint mi[N];
  int     mref[N];
  int     exp_q[$];
  int     got_q[$];

  always @(posedge clk)
    if (reset && spike_valid && spike_ready) got_q.push_back(int'(spike_id));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // One step of the reference: every neuron leaks, integrates, saturates, fires.
  task automatic model_step(input int lf, input int thr, input int rp);
    longint leak, s;
    for (int i = 0; i < N; i++) begin
      if (mref[i] > 0) begin
        mref[i]--;
        continue;
      end
      leak = (mv[i] * lf) / 65536;
      s = mv[i] - leak + mi[i];
      if (s > 65535) s = 65535;
      if (s >= thr) begin
        mv[i] = rp;
        exp_q.push_back(i);
`ifdef LIF_REFRACTORY_EN
        mref[i] = 2;
`endif
      end else begin
        mv[i] = s;
      end
    end
  endtask

  task automatic set_cur(input int i, input int val);
    @(negedge clk);
    cur_wr_en = 1'b1; cur_wr_addr = i[1:0]; cur_wr_data = val[15:0];
    @(negedge clk);
    cur_wr_en = 1'b0;
    mi[i] = val;
  endtask

  task automatic do_step(input int lf, input int thr, input int rp, input int exp_lat,
                         input int release_at, input bit retrig, input bit rand_rdy,
                         input string tag);
    int lat;
    @(negedge clk);
    leak_factor = lf[15:0]; threshold = thr[15:0]; reset_potential = rp[15:0];
    step_start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      step_start = retrig && (lat == 2);
      if (rand_rdy) spike_ready = 1'($urandom_range(0, 1));
      if (lat == release_at) begin
        chk({tag, "_stall_busy"}, step_busy, 1);
        chk({tag, "_stall_done"}, step_done, 0);
        chk({tag, "_stall_valid"}, spike_valid, 1);
        chk({tag, "_stall_vlast"}, dut.v_q[N-1], mv[N-1][31:0]);
        spike_ready = 1'b1;
      end
    end while (!step_done && lat < 300);
    step_start = 1'b0;
    chk({tag, "_done_seen"}, step_done, 1);
    if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, "_busy_low"}, step_busy, 0);
    chk({tag, "_done_pulse"}, step_done, 0);
    if (retrig) begin
      @(negedge clk);
      chk({tag, "_no_retrig"}, step_busy, 0);
    end
    model_step(lf, thr, rp);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_v%0d", tag, i), dut.v_q[i], mv[i][31:0]);
  endtask

  task automatic drain(input string tag);
    int k;
    spike_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (spike_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drained"}, spike_valid, 0);
    chk({tag, "_nspikes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_id%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mi[i] = 0; mref[i] = 0;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int expv0[4];
    expv0[0] = 10000; expv0[1] = 19500; expv0[2] = 28525; expv0[3] = 5000;

    reset = 1'b0; step_start = 1'b0; cur_wr_en = 1'b0; cur_wr_addr = '0;
    cur_wr_data = '0; spike_ready = 1'b1;
    leak_factor = '0; threshold = '0; reset_potential = '0;
    model_reset();
    #1;
    chk("rst_busy", step_busy, 0);
    chk("rst_done", step_done, 0);
    chk("rst_valid", spike_valid, 0);
    chk("rst_id", spike_id, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Single driven neuron climbs and fires on step 4.
    set_cur(0, 10000);
    for (int s = 0; s < 4; s++) begin
      do_step(3277, 30000, 5000, N + 1, 0, 1'b0, 1'b0, $sformatf("leak%0d", s));
      chk($sformatf("leak%0d_v0_const", s), dut.v_q[0], expv0[s]);
      chk($sformatf("leak%0d_nexp", s), exp_q.size(), (s == 3) ? 1 : 0);
      drain($sformatf("leak%0d", s));
    end

    // Zero current: no spikes, fixed latency; step_start during RUN is ignored.
    set_cur(0, 0);
    for (int s = 0; s < 3; s++) begin
      do_step(3277, 30000, 5000, N + 1, 0, (s == 1), 1'b0, $sformatf("quiet%0d", s));
      drain($sformatf("quiet%0d", s));
    end

    // Saturation: every neuron reaches the 65535 ceiling and fires.
    for (int i = 0; i < N; i++) set_cur(i, 65535);
    do_step(3277, 65535, 5000, N + 1, 0, 1'b0, 1'b0, "sat");
    chk("sat_nexp", exp_q.size(), N);
    drain("sat");

    // Backpressure: one leftover spike, then all fire with the consumer stalled.
    for (int i = 0; i < N; i++) set_cur(i, (i == 1) ? 65535 : 0);
    spike_ready = 1'b0;
    do_step(3277, 65535, 5000, N + 1, 0, 1'b0, 1'b0, "bp_pre");
    chk("bp_pre_valid", spike_valid, 1);
    chk("bp_pre_head", spike_id, 1);
    for (int i = 0; i < N; i++) set_cur(i, 65535);
    spike_ready = 1'b0;
    do_step(3277, 65535, 5000, 16, 15, 1'b0, 1'b0, "bp");
    drain("bp");

    // Reset mid-step at index 2, with spikes already queued.
    spike_ready = 1'b0;
    @(negedge clk);
    leak_factor = 16'd3277; threshold = 16'd65535; reset_potential = 16'd5000;
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_idx", dut.idx_q, 2);
    chk("mid_valid_pre", spike_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_busy", step_busy, 0);
    chk("mid_done", step_done, 0);
    chk("mid_valid", spike_valid, 0);
    chk("mid_id", spike_id, 0);
    for (int i = 0; i < N; i++) chk($sformatf("mid_v%0d", i), dut.v_q[i], 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    spike_ready = 1'b1;
    set_cur(2, 1234);
    do_step(3277, 30000, 5000, N + 1, 0, 1'b0, 1'b0, "post_rst");
    drain("post_rst");

`ifdef LIF_REFRACTORY_EN
    // Refractory: constant full current fires on steps 1, 4, 7.
    for (int i = 0; i < N; i++) set_cur(i, 65535);
    for (int s = 1; s <= 7; s++) begin
      bit fired0;
      do_step(0, 65535, 0, N + 1, 0, 1'b0, 1'b0, $sformatf("ref%0d", s));
      fired0 = 1'b0;
      foreach (exp_q[k]) if (exp_q[k] == 0) fired0 = 1'b1;
      chk($sformatf("ref%0d_fire0", s), 32'(fired0), (s == 1 || s == 4 || s == 7) ? 1 : 0);
      drain($sformatf("ref%0d", s));
    end
`endif

    // Random steps with random consumer readiness.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) set_cur(i, int'($urandom_range(0, 25000)));
      do_step(int'($urandom_range(0, 65535)), int'($urandom_range(1000, 40000)),
              int'($urandom_range(0, 5000)), (s < 2) ? 0 : 0, 0, 1'b0, 1'b1,
              $sformatf("rnd%0d", s));
      drain($sformatf("rnd%0d", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
